// File: rtl/mac_accumulator_pkg.sv
// rtl/mac_accumulator_pkg.sv - shared MAC datapath widths
package mac_accumulator_pkg;

  localparam int MAC_OP_W  = 16;
  localparam int MAC_ACC_W = 32;

endpackage

// File: rtl/mac_accumulator_adder.sv
// rtl/mac_accumulator_adder.sv - 32-bit ripple-carry adder shared by the MAC
module Adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  always_comb begin
    logic c;
    sum = '0;
    c   = cin;
    for (int i = 0; i < 32; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - two-stage multiply-accumulate emitting one result per LEN products
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAC_OP_W-1:0]  a,
  input  logic [MAC_OP_W-1:0]  b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAC_ACC_W-1:0] out_sum,
  output logic                 out_ovf
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  logic [MAC_ACC_W-1:0] p_reg;
  logic [MAC_ACC_W-1:0] acc;
  logic [MAC_ACC_W-1:0] sum;
  logic                 p_vld;
  logic                 ovf_acc;
  logic                 cout;
  logic [CNT_W-1:0]     cnt;
  logic                 last;
  logic                 stall;
  logic                 accept;
  logic                 consume;

  // Only the final product of a dot product can be blocked by a full output register.
  assign last     = (cnt == CNT_LAST);
  assign stall    = p_vld & last & out_valid & ~out_ready;
  assign in_ready = ~stall & ~clear;
  assign accept   = in_valid & in_ready;
  assign consume  = p_vld & ~stall & ~clear;

  Adder_32bit u_adder (
    .a   (acc),
    .b   (p_reg),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg <= '0;
      p_vld <= 1'b0;
    end else if (clear) begin
      p_vld <= 1'b0;
    end else if (accept) begin
      p_reg <= MAC_ACC_W'(a) * MAC_ACC_W'(b);
      p_vld <= 1'b1;
    end else if (consume) begin
      p_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (clear || (consume && last)) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (consume) begin
      acc     <= sum;
      cnt     <= cnt + CNT_W'(1);
      ovf_acc <= ovf_acc | cout;
    end
  end

  // A new result may replace the old one on the same edge as its handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (consume && last) begin
      out_valid <= 1'b1;
      out_sum   <= sum;
      out_ovf   <= ovf_acc | cout;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - directed and randomized checks of mac_accumulator
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_ovf;

  logic        clear1;
  logic        in_valid1;
  logic        in_ready1;
  logic [15:0] a1;
  logic [15:0] b1;
  logic        out_valid1;
  logic        out_ready1;
  logic [31:0] out_sum1;
  logic        out_ovf1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf)
  );

  mac_accumulator #(.LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_ovf(out_ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] pa, input logic [15:0] pb);
    a = pa;
    b = pb;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    chk("push in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] es, input logic eo);
    for (int i = 0; i < 50 && !out_valid; i++) tick();
    chk({tag, " valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, " sum"}, out_sum, es);
    chk({tag, " ovf"}, {31'd0, out_ovf}, {31'd0, eo});
  endtask

  task automatic push_n(input logic [15:0] pa, input logic [15:0] pb, input int n);
    for (int i = 0; i < n; i++) push(pa, pb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0]     expq[$];
    logic [32:0]     e;
    longint unsigned part;
    int              pcnt;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    clear1 = 1'b0; in_valid1 = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b1;
    #12;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_sum", out_sum, 32'd0);
    chk("reset out_ovf", {31'd0, out_ovf}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // basic dot product, exact latency and single-cycle valid
    for (int i = 1; i <= 4; i++) push(16'(i), 16'd10);
    chk("t1 not yet valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t1 valid", {31'd0, out_valid}, 32'd1);
    chk("t1 sum", out_sum, 32'd100);
    chk("t1 ovf", {31'd0, out_ovf}, 32'd0);
    tick();
    chk("t1 valid drops", {31'd0, out_valid}, 32'd0);

    // overflow then clean restart
    push_n(16'hFFFF, 16'hFFFF, 4);
    expect_result("t2 ovf", 32'hFFF80004, 1'b1);
    push_n(16'd1, 16'd1, 4);
    expect_result("t2 next", 32'd4, 1'b0);
    tick();

    // backpressure
    for (int i = 1; i <= 4; i++) push(16'(i), 16'd10);
    out_ready = 1'b0;
    expect_result("t3 first", 32'd100, 1'b0);
    push_n(16'd1, 16'd1, 4);
    chk("t3 stalled in_ready", {31'd0, in_ready}, 32'd0);
    tick(); tick();
    chk("t3 still stalled", {31'd0, in_ready}, 32'd0);
    chk("t3 held sum", out_sum, 32'd100);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3 replaced valid", {31'd0, out_valid}, 32'd1);
    chk("t3 replaced sum", out_sum, 32'd4);
    chk("t3 unstalled", {31'd0, in_ready}, 32'd1);
    tick();
    chk("t3 held second", out_sum, 32'd4);
    out_ready = 1'b1;
    tick();
    chk("t3 drained", {31'd0, out_valid}, 32'd0);

    // clear mid-operation with a pending result
    out_ready = 1'b0;
    push_n(16'd1, 16'd1, 4);
    expect_result("t4 pending", 32'd4, 1'b0);
    push_n(16'd5, 16'd5, 2);
    clear = 1'b1; in_valid = 1'b1; a = 16'd9; b = 16'd9;
    #1;
    chk("t4 clear in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("t4 pending kept valid", {31'd0, out_valid}, 32'd1);
    chk("t4 pending kept sum", out_sum, 32'd4);
    out_ready = 1'b1;
    tick();
    chk("t4 pending delivered", {31'd0, out_valid}, 32'd0);
    push_n(16'd1, 16'd2, 4);
    expect_result("t4 after clear", 32'd8, 1'b0);
    tick();

    // async reset mid-operation
    out_ready = 1'b0;
    push_n(16'd1, 16'd1, 4);
    expect_result("t5 pending", 32'd4, 1'b0);
    push_n(16'd3, 16'd3, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5 rst out_sum", out_sum, 32'd0);
    chk("t5 rst out_ovf", {31'd0, out_ovf}, 32'd0);
    chk("t5 rst in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    push_n(16'd2, 16'd3, 4);
    expect_result("t5 fresh", 32'd24, 1'b0);
    tick();

    // LEN=1 streaming
    in_valid1 = 1'b1; a1 = 16'd7; b1 = 16'd6;
    tick();
    a1 = 16'd0; b1 = 16'd0;
    tick();
    chk("t6 r0 valid", {31'd0, out_valid1}, 32'd1);
    chk("t6 r0 sum", out_sum1, 32'd42);
    a1 = 16'hFFFF; b1 = 16'd2;
    tick();
    chk("t6 r1 valid", {31'd0, out_valid1}, 32'd1);
    chk("t6 r1 sum", out_sum1, 32'd0);
    in_valid1 = 1'b0;
    tick();
    chk("t6 r2 valid", {31'd0, out_valid1}, 32'd1);
    chk("t6 r2 sum", out_sum1, 32'h1FFFE);
    chk("t6 r2 ovf", {31'd0, out_ovf1}, 32'd0);
    tick();
    chk("t6 idle", {31'd0, out_valid1}, 32'd0);

    // randomized traffic against a dot-product reference model
    part = 0;
    pcnt = 0;
    for (int c = 0; c < 460; c++) begin
      if (c < 400) begin
        in_valid  = ($urandom_range(9) < 7);
        a         = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
        b         = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
        out_ready = ($urandom_range(9) < 6);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (in_valid && in_ready) begin
        part += longint'(a) * longint'(b);
        pcnt++;
        if (pcnt == 4) begin
          expq.push_back({(part >= 64'h1_0000_0000), part[31:0]});
          part = 0;
          pcnt = 0;
        end
      end
      if (out_valid && out_ready) begin
        chk("rand result expected", {31'd0, (expq.size() > 0)}, 32'd1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("rand sum", out_sum, e[31:0]);
          chk("rand ovf", {31'd0, out_ovf}, {31'd0, e[32]});
        end
      end
      tick();
    end
    chk("rand all results seen", expq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
